// File: rtl/hazard_controller_pkg.sv
// Shared pipeline header: opcodes, hazard FSM encodings and the NOP word.
// Pure declarations, no latency or flow control of its own.
package hazard_controller_pkg;

    localparam logic [6:0] opcode_r   = 7'b0110011;
    localparam logic [6:0] opcode_imm = 7'b0010011;
    localparam logic [6:0] opcode_lw  = 7'b0000011;
    localparam logic [6:0] opcode_sw  = 7'b0100011;
    localparam logic [6:0] opcode_beq = 7'b1100011;

    localparam logic [31:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } hz_state_e;

    function automatic logic is_beq(input logic [31:0] ins);
        return ins[6:0] == opcode_beq;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// IF/ID boundary bundle: fetch side, ID/EX hazard inputs, IF/ID register and pipeline controls.
// Wires only; the controller reacts combinationally and there is no ready/valid backpressure.
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      if_ins_i;
    logic [31:0]      if_pc_i;
    logic             if_valid_i;
    logic [4:0]       ex_rd_i;
    logic             ex_memread_i;
    logic             branch_taken_i;
    logic             mem_stall_i;

    logic [31:0]      id_ins_o;
    logic [31:0]      id_pc_o;
    logic             id_valid_o;
    logic             pc_write_o;
    logic             idex_bubble_o;
    logic             pipe_hold_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output if_ins_i, if_pc_i, if_valid_i, ex_rd_i, ex_memread_i,
               branch_taken_i, mem_stall_i,
        input  id_ins_o, id_pc_o, id_valid_o, pc_write_o, idex_bubble_o,
               pipe_hold_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  if_ins_i, if_pc_i, if_valid_i, ex_rd_i, ex_memread_i,
               branch_taken_i, mem_stall_i,
        output id_ins_o, id_pc_o, id_valid_o, pc_write_o, idex_bubble_o,
               pipe_hold_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_controller_src_use_decode.sv
// Source-register extraction and use flags for an instruction word; shared with forwarding.
// Purely combinational, zero latency, no flow control.
module src_use_decode
    import hazard_controller_pkg::*;
(
    input  logic [31:0] ins_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic        use_rs1_o,
    output logic        use_rs2_o
);
    logic unused_bits;

    assign rs1_o       = ins_i[19:15];
    assign rs2_o       = ins_i[24:20];
    assign unused_bits = ^{ins_i[31:25], ins_i[14:7]};

    always_comb begin
        use_rs1_o = 1'b0;
        use_rs2_o = 1'b0;
        case (ins_i[6:0])
            opcode_r:   begin use_rs1_o = 1'b1; use_rs2_o = 1'b1; end
            opcode_imm: begin use_rs1_o = 1'b1; end
            opcode_lw:  begin use_rs1_o = 1'b1; end
            opcode_sw:  begin use_rs1_o = 1'b1; use_rs2_o = 1'b1; end
            opcode_beq: begin use_rs1_o = 1'b1; use_rs2_o = 1'b1; end
            default:    begin use_rs1_o = 1'b0; use_rs2_o = 1'b0; end
        endcase
    end
endmodule

// File: rtl/hazard_controller.sv
// IF/ID register plus load-use / branch-flush / memory-freeze sequencing; controls are same-cycle.
// IF/ID holds on any stall; mem_stall_i freezes everything and takes priority over hazards.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    hazard_controller_if.slave bus
);
    hz_state_e        state_q, state_d;
    hz_state_e        ret_q, ret_d;
    hz_state_e        eff_state;
    logic [1:0]       lu_cnt_q, lu_cnt_d;
    logic [31:0]      id_ins_q, id_ins_d;
    logic [31:0]      id_pc_q, id_pc_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             pc_write, idex_bubble, pipe_hold;
    logic [4:0]       rs1, rs2;
    logic             use_rs1, use_rs2;
    logic             lu_hit, br_flush;

    src_use_decode u_src_use_decode (
        .ins_i     (id_ins_q),
        .rs1_o     (rs1),
        .rs2_o     (rs2),
        .use_rs1_o (use_rs1),
        .use_rs2_o (use_rs2)
    );

    assign lu_hit = id_valid_q & bus.ex_memread_i & (bus.ex_rd_i != 5'd0) &
                    ((use_rs1 & (rs1 == bus.ex_rd_i)) | (use_rs2 & (rs2 == bus.ex_rd_i)));
    assign br_flush = id_valid_q & is_beq(id_ins_q) & bus.branch_taken_i;

    // Once memory releases, FREEZE behaves exactly like the state it interrupted.
    assign eff_state = (state_q == FREEZE) ? ret_q : state_q;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        lu_cnt_d    = lu_cnt_q;
        id_ins_d    = id_ins_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_write    = 1'b1;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;

        if (rst_i) begin
            pc_write    = 1'b0;
            idex_bubble = 1'b1;
        end else if (bus.mem_stall_i) begin
            pc_write  = 1'b0;
            pipe_hold = 1'b1;
            state_d   = FREEZE;
            ret_d     = eff_state;
        end else if (eff_state == LU_STALL) begin
            pc_write    = 1'b0;
            idex_bubble = 1'b1;
            if (lu_cnt_q == 2'd1) begin
                state_d  = RUN;
                lu_cnt_d = 2'd0;
            end else begin
                state_d  = LU_STALL;
                lu_cnt_d = lu_cnt_q - 2'd1;
            end
        end else if (lu_hit) begin
            pc_write    = 1'b0;
            idex_bubble = 1'b1;
            if (LU_CYCLES > 1) begin
                state_d  = LU_STALL;
                lu_cnt_d = 2'(LU_CYCLES - 1);
            end else begin
                state_d  = RUN;
            end
        end else if (br_flush) begin
            // Wrong-path fetch is dropped; the PC mux already steers to the target.
            state_d    = RUN;
            id_ins_d   = NOP;
            id_valid_d = 1'b0;
            id_pc_d    = bus.if_pc_i;
            if (flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
        end else begin
            state_d    = RUN;
            id_ins_d   = bus.if_ins_i;
            id_pc_d    = bus.if_pc_i;
            id_valid_d = bus.if_valid_i;
        end

        if (!rst_i && !pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            lu_cnt_q    <= 2'd0;
            id_ins_q    <= NOP;
            id_pc_q     <= 32'h0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            lu_cnt_q    <= lu_cnt_d;
            id_ins_q    <= id_ins_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.id_ins_o      = id_ins_q;
    assign bus.id_pc_o       = id_pc_q;
    assign bus.id_valid_o    = id_valid_q;
    assign bus.pc_write_o    = pc_write;
    assign bus.idex_bubble_o = idex_bubble;
    assign bus.pipe_hold_o   = pipe_hold;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
endmodule
